// File: rtl/vga_pixel_timing.sv
// Raster timing generator and 24-bit RGB stream sink that locks to stream start-of-frame.
// Define VGA_TEST_PATTERN_EN to build the internal colour-bar generator selected by test_en.
module vga_pixel_timing #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter logic        SYNC_POL      = 1'b0,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
    input  logic        test_en,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank,
    output logic [7:0]  vga_red,
    output logic [7:0]  vga_green,
    output logic [7:0]  vga_blue,
    output logic        frame_start,
    output logic [15:0] underflow_cnt,
    output logic        resync
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HC_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] VC_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] HA_END  = 11'(H_ACTIVE);
    localparam logic [10:0] VA_END  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t      r_state;
    logic [10:0] r_hc;
    logic [10:0] r_vc;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic [23:0] r_rgb;
    logic        r_frame_start;
    logic        r_resync;
    logic [15:0] r_underflow_cnt;

    logic        w_active;
    logic        w_origin;
    logic        w_hsync_on;
    logic        w_vsync_on;
    logic        w_sof_early;
    logic        w_tp_on;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_rgb;
    logic        w_resync;
    logic        w_uf_inc;
    state_t      w_state_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == HC_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + 11'd1;
        end else begin
            r_hc <= r_hc + 11'd1;
        end
    end

    assign w_active    = (r_hc < HA_END) && (r_vc < VA_END);
    assign w_origin    = (r_hc == '0) && (r_vc == '0);
    assign w_hsync_on  = (r_hc >= HS_BEG) && (r_hc < HS_END);
    assign w_vsync_on  = (r_vc >= VS_BEG) && (r_vc < VS_END);
    assign w_sof_early = pix_valid && pix_sof && !w_origin;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

    logic [10:0] w_bar_col;
    logic [2:0]  w_bar_sel;

    // Bar order white..black is the binary count with R=~b1, G=~b2, B=~b0.
    assign w_bar_col = r_hc / BAR_W;
    assign w_bar_sel = (w_bar_col > 11'd7) ? 3'd7 : w_bar_col[2:0];
    assign w_bar_rgb = {{8{~w_bar_sel[1]}}, {8{~w_bar_sel[2]}}, {8{~w_bar_sel[0]}}};
    assign w_tp_on   = test_en;
`else
    logic w_unused_test_en;

    assign w_unused_test_en = test_en;
    assign w_bar_rgb        = '0;
    assign w_tp_on          = 1'b0;
`endif

    always_comb begin
        pix_ready = 1'b0;
        if (!w_tp_on) begin
            if (r_state == ST_HUNT) begin
                pix_ready = pix_valid && (!pix_sof || w_origin);
            end else begin
                pix_ready = w_active && !w_sof_early;
            end
        end
    end

    always_comb begin
        w_rgb       = '0;
        w_resync    = 1'b0;
        w_uf_inc    = 1'b0;
        w_state_nxt = r_state;
        if (w_tp_on) begin
            if (w_active) begin
                w_rgb = w_bar_rgb;
            end
        end else if (r_state == ST_HUNT) begin
            if (w_origin && pix_valid && pix_sof) begin
                w_rgb       = pix_data;
                w_state_nxt = ST_LOCK;
            end
        end else if (w_active) begin
            // A missing pixel is not waited for: its slot is filled and the stream moves on.
            if (!pix_valid) begin
                w_rgb    = UNDERFLOW_RGB;
                w_uf_inc = 1'b1;
            end else if (w_sof_early) begin
                w_resync    = 1'b1;
                w_state_nxt = ST_HUNT;
            end else begin
                w_rgb = pix_data;
                if (w_origin && !pix_sof) begin
                    w_resync    = 1'b1;
                    w_state_nxt = ST_HUNT;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state         <= ST_HUNT;
            r_hsync         <= ~SYNC_POL;
            r_vsync         <= ~SYNC_POL;
            r_blank         <= 1'b1;
            r_rgb           <= '0;
            r_frame_start   <= 1'b0;
            r_resync        <= 1'b0;
            r_underflow_cnt <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_hsync       <= w_hsync_on ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vsync_on ? SYNC_POL : ~SYNC_POL;
            r_blank       <= ~w_active;
            r_rgb         <= w_rgb;
            r_frame_start <= w_origin;
            r_resync      <= w_resync;
            if (w_uf_inc && (r_underflow_cnt != '1)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'd1;
            end
        end
    end

    assign vga_hsync     = r_hsync;
    assign vga_vsync     = r_vsync;
    assign vga_blank     = r_blank;
    assign vga_red       = r_rgb[23:16];
    assign vga_green     = r_rgb[15:8];
    assign vga_blue      = r_rgb[7:0];
    assign frame_start   = r_frame_start;
    assign resync        = r_resync;
    assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Self-checking bench for vga_pixel_timing using small raster parameters (14x7, 98-cycle frame).
// Expected pins come from a position/lock model computed with modulo arithmetic per cycle.
module tb_vga_pixel_timing;

    localparam int HA    = 8;
    localparam int HT    = 14;
    localparam int VA    = 4;
    localparam int VT    = 7;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] UF_RGB = 24'hFF00FF;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [23:0] pix_data = '0;
    logic        test_en = 1'b0;
    logic        pix_ready;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank;
    logic [7:0]  vga_red;
    logic [7:0]  vga_green;
    logic [7:0]  vga_blue;
    logic        frame_start;
    logic [15:0] underflow_cnt;
    logic        resync;

    logic [23:0] bars [8];
    int total = 0;
    int bad = 0;

    int m_t = 0;
    bit m_lock = 1'b0;
    int m_uf = 0;

    int s_k = 0;
    logic [23:0] s_d = '0;

    vga_pixel_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .UNDERFLOW_RGB(24'hFF00FF)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
        .test_en(test_en),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .frame_start(frame_start), .underflow_cnt(underflow_cnt), .resync(resync)
    );

    always #5 CLK = ~CLK;

    // Pins packed as {hsync, vsync, blank, rgb[23:0], frame_start, resync}.
    function automatic void model_cycle(input logic v, input logic s, input logic [23:0] d,
                                        input logic te, output logic rdy, output logic [28:0] o);
        int h;
        int ln;
        bit act;
        bit org;
        bit tp;
        logic [23:0] rgb;
        logic rs;
        h   = m_t % HT;
        ln  = (m_t / HT) % VT;
        act = (h < HA) && (ln < VA);
        org = (h == 0) && (ln == 0);
        rgb = '0;
        rs  = 1'b0;
        rdy = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        tp = te;
`else
        tp = te && 1'b0;
`endif
        if (tp) begin
            if (act) rgb = bars[h / (HA / 8)];
        end else if (!m_lock) begin
            rdy = v && (!s || org);
            if (org && v && s) begin
                rgb = d;
                m_lock = 1'b1;
            end
        end else begin
            rdy = act && !(v && s && !org);
            if (act) begin
                if (!v) begin
                    rgb = UF_RGB;
                    if (m_uf < 65535) m_uf++;
                end else if (s && !org) begin
                    rs = 1'b1;
                    m_lock = 1'b0;
                end else begin
                    rgb = d;
                    if (!s && org) begin
                        rs = 1'b1;
                        m_lock = 1'b0;
                    end
                end
            end
        end
        o = {(h >= 10 && h < 12) ? 1'b0 : 1'b1, (ln == 5) ? 1'b0 : 1'b1, !act, rgb, org, rs};
        m_t++;
    endfunction

    task automatic cycle(input logic v, input logic s, input logic [23:0] d,
                         output logic er, output logic ar, output logic [28:0] eo,
                         output logic [28:0] ao, output logic [15:0] eu, output logic [15:0] au);
        @(negedge CLK);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        model_cycle(v, s, d, test_en, er, eo);
        eu = 16'(m_uf);
        #1 ar = pix_ready;
        @(posedge CLK);
        #1;
        ao = {vga_hsync, vga_vsync, vga_blank, vga_red, vga_green, vga_blue, frame_start, resync};
        au = underflow_cnt;
    endtask

    task automatic src_next();
        s_k = (s_k + 1) % 32;
        s_d = 24'($urandom);
    endtask

    task automatic test_reset();
        logic [44:0] got;
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        test_en = 1'b0;
        #1;
        got = {vga_hsync, vga_vsync, vga_blank, vga_red, vga_green, vga_blue,
               frame_start, resync, underflow_cnt};
        total++;
        if (got !== {3'b111, 24'h0, 2'b00, 16'h0}) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", got, {3'b111, 24'h0, 2'b00, 16'h0});
        end
        @(posedge CLK);
        #2 RST_N = 1'b1;
        m_t = 0;
        m_lock = 1'b0;
        m_uf = 0;
    endtask

    task automatic test_no_stream();
        logic er, ar;
        logic [28:0] eo, ao;
        logic [15:0] eu, au;
        for (int c = 0; c < 2 * FRAME; c++) begin
            cycle(1'b0, 1'($urandom), 24'($urandom), er, ar, eo, ao, eu, au);
            total += 3;
            if (ar !== er) begin bad++; $display("FAIL no_stream ready t=%0d got=%b exp=%b", c, ar, er); end
            if (ao !== eo) begin bad++; $display("FAIL no_stream pins t=%0d got=%h exp=%h", c, ao, eo); end
            if (au !== eu) begin bad++; $display("FAIL no_stream ufcnt t=%0d got=%h exp=%h", c, au, eu); end
        end
    endtask

    task automatic test_lock_stream();
        logic er, ar;
        logic [28:0] eo, ao;
        logic [15:0] eu, au;
        int acc = 0;
        s_k = 0;
        s_d = 24'($urandom);
        for (int c = 0; c < 3 * FRAME; c++) begin
            cycle(1'b1, s_k == 0, s_d, er, ar, eo, ao, eu, au);
            total += 3;
            if (ar !== er) begin bad++; $display("FAIL lock_stream ready t=%0d got=%b exp=%b", c, ar, er); end
            if (ao !== eo) begin bad++; $display("FAIL lock_stream pins t=%0d got=%h exp=%h", c, ao, eo); end
            if (au !== eu) begin bad++; $display("FAIL lock_stream ufcnt t=%0d got=%h exp=%h", c, au, eu); end
            if (ar) acc++;
            if (er) src_next();
        end
        total++;
        if (acc !== 96) begin bad++; $display("FAIL lock_stream accepted got=%0d exp=96", acc); end
    endtask

    task automatic test_underflow();
        logic er, ar, v;
        logic [28:0] eo, ao;
        logic [15:0] eu, au;
        int j0, j1, h, ln, slot;
        bit drop;
        j0 = $urandom_range(0, 29);
        j1 = $urandom_range(0, 27);
        s_k = 0;
        s_d = 24'($urandom);
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                h = c % HT;
                ln = c / HT;
                slot = ln * HA + h;
                drop = (h < HA) && (ln < VA) &&
                       ((f == 1 && slot >= j0 && slot < j0 + 3) || (f == 3 && slot >= j1 && slot < j1 + 5));
                v = !drop;
                cycle(v, s_k == 0, s_d, er, ar, eo, ao, eu, au);
                total += 3;
                if (ar !== er) begin bad++; $display("FAIL underflow ready f=%0d c=%0d got=%b exp=%b", f, c, ar, er); end
                if (ao !== eo) begin bad++; $display("FAIL underflow pins f=%0d c=%0d got=%h exp=%h", f, c, ao, eo); end
                if (au !== eu) begin bad++; $display("FAIL underflow ufcnt f=%0d c=%0d got=%h exp=%h", f, c, au, eu); end
                if (er || drop) src_next();
                if (f == 2 && c == 60) begin
                    force dut.r_underflow_cnt = 16'hFFFD;
                    m_uf = 65533;
                end
                if (f == 2 && c == 61) release dut.r_underflow_cnt;
            end
            if (f == 1) begin
                total++;
                if (underflow_cnt !== 16'd3) begin bad++; $display("FAIL underflow_three got=%0d exp=3", underflow_cnt); end
            end
            if (f == 3) begin
                total++;
                if (underflow_cnt !== 16'hFFFF) begin bad++; $display("FAIL underflow_saturate got=%h exp=ffff", underflow_cnt); end
            end
        end
    endtask

    task automatic test_resync();
        logic er, ar;
        logic [28:0] eo, ao;
        logic [15:0] eu, au;
        logic [23:0] held = '0;
        s_k = 0;
        s_d = 24'($urandom);
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                if (f == 1 && c == 17) begin
                    s_k = 0;
                    s_d = 24'($urandom);
                    held = s_d;
                end
                cycle(1'b1, s_k == 0, s_d, er, ar, eo, ao, eu, au);
                total += 3;
                if (ar !== er) begin bad++; $display("FAIL resync ready f=%0d c=%0d got=%b exp=%b", f, c, ar, er); end
                if (ao !== eo) begin bad++; $display("FAIL resync pins f=%0d c=%0d got=%h exp=%h", f, c, ao, eo); end
                if (au !== eu) begin bad++; $display("FAIL resync ufcnt f=%0d c=%0d got=%h exp=%h", f, c, au, eu); end
                if (f == 1 && c == 17) begin
                    total++;
                    if ({ar, ao[0]} !== 2'b01) begin bad++; $display("FAIL resync_event ready/pulse got=%b exp=01", {ar, ao[0]}); end
                end
                if (f == 2 && c == 0) begin
                    total++;
                    if (ao[25:2] !== held) begin bad++; $display("FAIL resync_relock_pixel got=%h exp=%h", ao[25:2], held); end
                end
                if (er) src_next();
            end
        end
    endtask

    task automatic test_midframe();
        logic er, ar, v;
        logic [28:0] eo, ao;
        logic [15:0] eu, au;
        int acc = 0;
        for (int c = 0; c < 3 * FRAME + 40; c++) begin
            if (c == 30) begin
                s_k = 5;
                s_d = 24'($urandom);
            end
            v = (c >= 30);
            cycle(v, v && (s_k == 0), s_d, er, ar, eo, ao, eu, au);
            total += 3;
            if (ar !== er) begin bad++; $display("FAIL midframe ready t=%0d got=%b exp=%b", c, ar, er); end
            if (ao !== eo) begin bad++; $display("FAIL midframe pins t=%0d got=%h exp=%h", c, ao, eo); end
            if (au !== eu) begin bad++; $display("FAIL midframe ufcnt t=%0d got=%h exp=%h", c, au, eu); end
            if (c == 30) begin
                total++;
                if (ar !== 1'b1) begin bad++; $display("FAIL midframe_discard ready got=%b exp=1", ar); end
            end
            if (c >= 2 * FRAME && c < 3 * FRAME && ar) acc++;
            if (v && er) src_next();
        end
        total++;
        if (acc !== 32) begin bad++; $display("FAIL midframe_locked_frame accepted got=%0d exp=32", acc); end
    endtask

    task automatic test_pattern();
        logic er, ar;
        logic [28:0] eo, ao;
        logic [15:0] eu, au;
        s_k = 0;
        s_d = 24'($urandom);
        for (int f = 0; f < 3; f++) begin
            test_en = (f == 1);
            for (int c = 0; c < FRAME; c++) begin
                cycle(1'b1, s_k == 0, s_d, er, ar, eo, ao, eu, au);
                total += 3;
                if (ar !== er) begin bad++; $display("FAIL pattern ready f=%0d c=%0d got=%b exp=%b", f, c, ar, er); end
                if (ao !== eo) begin bad++; $display("FAIL pattern pins f=%0d c=%0d got=%h exp=%h", f, c, ao, eo); end
                if (au !== eu) begin bad++; $display("FAIL pattern ufcnt f=%0d c=%0d got=%h exp=%h", f, c, au, eu); end
`ifdef VGA_TEST_PATTERN_EN
                if (f == 1 && c < HA) begin
                    total++;
                    if (ao[25:2] !== bars[c]) begin bad++; $display("FAIL pattern_bar c=%0d got=%h exp=%h", c, ao[25:2], bars[c]); end
                end
`endif
                if (er) src_next();
            end
        end
        test_en = 1'b0;
    endtask

    initial begin
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        test_reset();
        test_no_stream();
        test_reset();
        test_lock_stream();
        test_reset();
        test_underflow();
        test_reset();
        test_resync();
        test_reset();
        test_midframe();
        test_reset();
        test_pattern();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
